// File: rtl/ap_hs_initiator.sv
`default_nettype none
// ap_hs_initiator: drives the ap_ctrl_hs start/ready/done handshake of an HLS kernel,
// returning the captured result, start-to-done latency and a completed-transaction count.
module ap_hs_initiator #(
  parameter int DATA_W = 3,
  parameter int RES_W  = 4,
  parameter int LAT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  output logic [DATA_W-1:0] dut_a,
  output logic [DATA_W-1:0] dut_b,
  input  logic [RES_W-1:0]  dut_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_sum,
  output logic [LAT_W-1:0]  rsp_latency,
  output logic [LAT_W-1:0]  txn_count,
  output logic              busy,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ap_start_q, ap_start_d;
  logic [DATA_W-1:0]  dut_a_q, dut_a_d;
  logic [DATA_W-1:0]  dut_b_q, dut_b_d;
  logic [RES_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic [LAT_W-1:0]   rsp_lat_q, rsp_lat_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_W-1:0]   lat_inc;
  logic [LAT_W-1:0]   txn_q, txn_d;
  logic               perr_q, perr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ap_start_q <= 1'b0;
      dut_a_q    <= '0;
      dut_b_q    <= '0;
      rsp_sum_q  <= '0;
      rsp_lat_q  <= '0;
      lat_q      <= '0;
      txn_q      <= '0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ap_start_q <= ap_start_d;
      dut_a_q    <= dut_a_d;
      dut_b_q    <= dut_b_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_lat_q  <= rsp_lat_d;
      lat_q      <= lat_d;
      txn_q      <= txn_d;
      perr_q     <= perr_d;
    end
  end

  // lat_q always holds the inclusive cycle count of the current cycle, so it is
  // loaded with 1 on accept and captured as-is when ap_done arrives.
  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  always_comb begin
    state_d    = state_q;
    ap_start_d = 1'b0;
    dut_a_d    = dut_a_q;
    dut_b_d    = dut_b_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_lat_d  = rsp_lat_q;
    lat_d      = lat_q;
    txn_d      = txn_q;
    perr_d     = perr_q;
    unique case (state_q)
      IDLE: begin
        if (ap_done) perr_d = 1'b1;
        if (req_valid) begin
          dut_a_d    = req_a;
          dut_b_d    = req_b;
          lat_d      = LAT_W'(1);
          ap_start_d = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        lat_d = lat_inc;
        if (ap_done) begin
          rsp_sum_d = dut_sum;
          rsp_lat_d = lat_q;
          state_d   = RESP;
          if (!ap_ready) perr_d = 1'b1;
        end else if (ap_ready) begin
          state_d = WAIT_DONE;
        end else begin
          ap_start_d = 1'b1;
        end
      end
      WAIT_DONE: begin
        lat_d = lat_inc;
        if (ap_done) begin
          rsp_sum_d = dut_sum;
          rsp_lat_d = lat_q;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (ap_done) perr_d = 1'b1;
        if (rsp_ready) begin
          txn_d   = txn_q + LAT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready    = (state_q == IDLE);
  assign ap_start     = ap_start_q;
  assign dut_a        = dut_a_q;
  assign dut_b        = dut_b_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_sum      = rsp_sum_q;
  assign rsp_latency  = rsp_lat_q;
  assign txn_count    = txn_q;
  assign busy         = (state_q != IDLE);
  assign protocol_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ap_hs_initiator.sv
`default_nettype none
// Directed bench for ap_hs_initiator: default-width instance plus a LAT_W=4 instance
// for latency saturation; the bench plays the kernel cycle by cycle.
module tb_ap_hs_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_a, req_b;
  logic        ap_start, ap_ready, ap_done;
  logic [2:0]  dut_a, dut_b;
  logic [3:0]  dut_sum;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_sum;
  logic [15:0] rsp_latency, txn_count;
  logic        busy, protocol_err;

  logic        s_req_valid, s_req_ready;
  logic [2:0]  s_req_a, s_req_b;
  logic        s_ap_start, s_ap_ready, s_ap_done;
  logic [2:0]  s_dut_a, s_dut_b;
  logic [3:0]  s_dut_sum;
  logic        s_rsp_valid, s_rsp_ready;
  logic [3:0]  s_rsp_sum;
  logic [3:0]  s_rsp_latency, s_txn_count;
  logic        s_busy, s_protocol_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ap_hs_initiator u_dut (
    .clock(clk), .reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_latency(rsp_latency), .txn_count(txn_count), .busy(busy),
    .protocol_err(protocol_err)
  );

  ap_hs_initiator #(.DATA_W(3), .RES_W(4), .LAT_W(4)) u_sat (
    .clock(clk), .reset(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_a(s_req_a), .req_b(s_req_b), .ap_start(s_ap_start), .ap_ready(s_ap_ready),
    .ap_done(s_ap_done), .dut_a(s_dut_a), .dut_b(s_dut_b), .dut_sum(s_dut_sum),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_sum(s_rsp_sum),
    .rsp_latency(s_rsp_latency), .txn_count(s_txn_count), .busy(s_busy),
    .protocol_err(s_protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Issues one request and acts as the kernel until rsp_valid rises.
  // Cycle k=1 is the first ap_start-high cycle; 0 for rdy_k/done_k means never.
  task automatic run_to_rsp(input logic [2:0] a, input logic [2:0] b,
                            input int rdy_k, input int done_k, output int starts);
    bit got;
    starts    = 0;
    got       = 1'b0;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (ap_start) starts++;
      ap_ready = (k == rdy_k);
      ap_done  = (k == done_k);
      dut_sum  = ap_done ? ({1'b0, dut_a} + {1'b0, dut_b}) : 4'hF;
      tick();
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      dut_sum  = 4'hF;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL rsp_timeout: got rsp_valid=0 required 1 within 64 cycles");
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rsp_drop: got rsp_valid=%0b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_a     = 3'd5;
    req_b     = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ap_start, rsp_valid, busy, protocol_err, dut_a, dut_b, rsp_sum} !== 15'd0 ||
          rsp_latency !== 16'd0 || txn_count !== 16'd0) begin
        fails++;
        $display("FAIL reset_outputs: got start=%0b valid=%0b busy=%0b perr=%0b a=%0d b=%0d sum=%0d lat=%0d txn=%0d required all 0",
                 ap_start, rsp_valid, busy, protocol_err, dut_a, dut_b, rsp_sum, rsp_latency, txn_count);
      end
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || ap_start !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got req_ready=%0b ap_start=%0b busy=%0b required 1 0 0",
               req_ready, ap_start, busy);
    end
  endtask

  task automatic test_pipelined_kernel();
    int starts;
    run_to_rsp(3'd5, 3'd6, 2, 5, starts);
    checks++;
    if (starts != 2) begin
      fails++;
      $display("FAIL pipe_start_cycles: got %0d required 2", starts);
    end
    checks++;
    if (rsp_sum !== 4'd11 || rsp_latency !== 16'd5) begin
      fails++;
      $display("FAIL pipe_result: got sum=%0d lat=%0d required sum=11 lat=5", rsp_sum, rsp_latency);
    end
    consume();
    checks++;
    if (txn_count !== 16'd1 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL pipe_txn: got txn=%0d req_ready=%0b required 1 1", txn_count, req_ready);
    end
  endtask

  task automatic test_comb_kernel();
    int starts;
    run_to_rsp(3'd7, 3'd7, 1, 1, starts);
    checks++;
    if (starts != 1 || rsp_sum !== 4'd14 || rsp_latency !== 16'd1) begin
      fails++;
      $display("FAIL comb_result: got starts=%0d sum=%0d lat=%0d required 1 14 1",
               starts, rsp_sum, rsp_latency);
    end
    checks++;
    if (protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL comb_perr: got %0b required 0", protocol_err);
    end
    consume();
    checks++;
    if (txn_count !== 16'd2) begin
      fails++;
      $display("FAIL comb_txn: got %0d required 2", txn_count);
    end
  endtask

  task automatic test_backpressure();
    int starts;
    do_reset(1);
    run_to_rsp(3'd3, 3'd4, 1, 1, starts);
    req_a     = 3'd1;
    req_b     = 3'd2;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 4'd7 || req_ready !== 1'b0 ||
          ap_start !== 1'b0 || dut_a !== 3'd3) begin
        fails++;
        $display("FAIL bp_hold: cycle %0d got valid=%0b sum=%0d req_ready=%0b start=%0b a=%0d required 1 7 0 0 3",
                 i, rsp_valid, rsp_sum, req_ready, ap_start, dut_a);
      end
    end
    consume();
    run_to_rsp(3'd1, 3'd2, 1, 1, starts);
    checks++;
    if (rsp_sum !== 4'd3) begin
      fails++;
      $display("FAIL bp_next_sum: got %0d required 3", rsp_sum);
    end
    consume();
    checks++;
    if (txn_count !== 16'd2) begin
      fails++;
      $display("FAIL bp_txn: got %0d required 2", txn_count);
    end
  endtask

  task automatic test_protocol_err();
    int starts;
    do_reset(1);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    tick();
    checks++;
    if (protocol_err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL perr_idle: got perr=%0b busy=%0b required 1 0", protocol_err, busy);
    end
    run_to_rsp(3'd2, 3'd2, 2, 3, starts);
    consume();
    checks++;
    if (protocol_err !== 1'b1 || rsp_sum !== 4'd4 || rsp_latency !== 16'd3) begin
      fails++;
      $display("FAIL perr_sticky: got perr=%0b sum=%0d lat=%0d required 1 4 3",
               protocol_err, rsp_sum, rsp_latency);
    end
    do_reset(1);
    checks++;
    if (protocol_err !== 1'b0) begin
      fails++;
      $display("FAIL perr_clear: got %0b required 0", protocol_err);
    end
    // ap_done without ap_ready while in START
    run_to_rsp(3'd6, 3'd1, 0, 1, starts);
    checks++;
    if (protocol_err !== 1'b1 || rsp_sum !== 4'd7 || rsp_latency !== 16'd1) begin
      fails++;
      $display("FAIL perr_start: got perr=%0b sum=%0d lat=%0d required 1 7 1",
               protocol_err, rsp_sum, rsp_latency);
    end
    consume();
  endtask

  task automatic test_saturation();
    bit got;
    got         = 1'b0;
    s_req_a     = 3'd2;
    s_req_b     = 3'd3;
    s_req_valid = 1'b1;
    tick();
    s_req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      s_ap_ready = (k == 2);
      s_ap_done  = (k == 20);
      s_dut_sum  = s_ap_done ? 4'd5 : 4'hF;
      tick();
      s_ap_ready = 1'b0;
      s_ap_done  = 1'b0;
      if (s_rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got || s_rsp_latency !== 4'd15 || s_rsp_sum !== 4'd5) begin
      fails++;
      $display("FAIL sat_latency: got valid=%0b lat=%0d sum=%0d required 1 15 5",
               got, s_rsp_latency, s_rsp_sum);
    end
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    checks++;
    if (s_txn_count !== 4'd1 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL sat_txn: got txn=%0d busy=%0b required 1 0", s_txn_count, s_busy);
    end
  endtask

  task automatic test_reset_in_wait();
    req_a     = 3'd4;
    req_b     = 3'd1;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ap_ready  = 1'b1;
    tick();
    ap_ready  = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || ap_start !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL wait_state: got busy=%0b start=%0b valid=%0b required 1 0 0",
               busy, ap_start, rsp_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (ap_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || txn_count !== 16'd0) begin
      fails++;
      $display("FAIL wait_reset: got start=%0b busy=%0b valid=%0b txn=%0d required 0 0 0 0",
               ap_start, busy, rsp_valid, txn_count);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || txn_count !== 16'd0) begin
        fails++;
        $display("FAIL wait_abort: cycle %0d got valid=%0b req_ready=%0b txn=%0d required 0 1 0",
                 i, rsp_valid, req_ready, txn_count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0;
    ap_ready = 1'b0; ap_done = 1'b0; dut_sum = 4'hF; rsp_ready = 1'b0;
    s_req_valid = 1'b0; s_req_a = '0; s_req_b = '0;
    s_ap_ready = 1'b0; s_ap_done = 1'b0; s_dut_sum = 4'hF; s_rsp_ready = 1'b0;
    test_reset();
    test_pipelined_kernel();
    test_comb_kernel();
    test_backpressure();
    test_protocol_err();
    test_saturation();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
